// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the elastic pipeline-stage registers.
//   stage_state_e : occupancy state of a pipe_stage_reg instance
//   *_W           : stage bundle widths for ID/EX, EX/MEM, MEM/WB
//   IDEX_*        : bit offsets of the fields in the ID/EX bundle
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int unsigned ID_EX_W  = 150;
  localparam int unsigned EX_MEM_W = 71;  // WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, Val_Rm, Dest
  localparam int unsigned MEM_WB_W = 70;  // WB_EN, MEM_R_EN, ALU_res, Mem_data, Dest

  // ID/EX field offsets (LSB position and width); control occupies the low bits.
  localparam int unsigned IDEX_CTRL_LSB   = 0;
  localparam int unsigned IDEX_CTRL_W     = 5;
  localparam int unsigned IDEX_SR_LSB     = 5;
  localparam int unsigned IDEX_SR_W       = 4;
  localparam int unsigned IDEX_CMD_LSB    = 9;
  localparam int unsigned IDEX_CMD_W      = 4;
  localparam int unsigned IDEX_PC_LSB     = 13;
  localparam int unsigned IDEX_PC_W       = 32;
  localparam int unsigned IDEX_RN_LSB     = 45;
  localparam int unsigned IDEX_RN_W       = 32;
  localparam int unsigned IDEX_RM_LSB     = 77;
  localparam int unsigned IDEX_RM_W       = 32;
  localparam int unsigned IDEX_IMM_LSB    = 109;
  localparam int unsigned IDEX_IMM_W      = 1;
  localparam int unsigned IDEX_SHOP_LSB   = 110;
  localparam int unsigned IDEX_SHOP_W     = 12;
  localparam int unsigned IDEX_SIMM24_LSB = 122;
  localparam int unsigned IDEX_SIMM24_W   = 24;
  localparam int unsigned IDEX_DEST_LSB   = 146;
  localparam int unsigned IDEX_DEST_W     = 4;

  // ID/EX payload, MSB first so that the packed layout matches the offsets above.
  typedef struct packed {
    logic [IDEX_DEST_W-1:0]   dest;
    logic [IDEX_SIMM24_W-1:0] signed_imm_24;
    logic [IDEX_SHOP_W-1:0]   shift_operand;
    logic                     imm;
    logic [IDEX_RM_W-1:0]     val_rm;
    logic [IDEX_RN_W-1:0]     val_rn;
    logic [IDEX_PC_W-1:0]     pc;
    logic [IDEX_CMD_W-1:0]    exe_cmd;
    logic [IDEX_SR_W-1:0]     sr;
    logic                     wb_en;
    logic                     mem_r_en;
    logic                     mem_w_en;
    logic                     b;
    logic                     s;
  } id_ex_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count this cycle
//   clear    : synchronous clear, dominates inc
//   cnt      : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  // Count register; increments are suppressed once all bits are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with a 2-entry skid buffer.
//   clk, rst            : clock, asynchronous active-low reset
//   flush               : synchronous flush; held entries become bubbles
//   freeze              : forces effective downstream ready low
//   in_valid/in_ready   : upstream handshake (in_ready decoded from state only)
//   in_data             : upstream bundle
//   out_valid/out_ready : downstream handshake
//   out_data            : output bundle; control bits are 0 whenever out_valid is 0
//   occupancy           : number of held entries (0..2)
//   stall_cnt           : saturating count of cycles with out_valid & ~effective ready
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 150,
  parameter int unsigned CTRL_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 freeze,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  // Ones over the control field; a shift by WIDTH yields 0 so the subtract gives all-ones.
  localparam logic [WIDTH-1:0] CTRL_MASK = (WIDTH'(1) << CTRL_WIDTH) - WIDTH'(1);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             rdy_eff, in_fire, out_fire;

  assign rdy_eff  = out_ready & ~freeze;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & rdy_eff;
  assign out_data = main_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = TWO;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        TWO:     if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake and occupancy decode, from the state register only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  // Entry storage. Control bits of main are cleared whenever the stage becomes
  // empty (drain or flush), so the registered output is a NOP bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= main_q & ~CTRL_MASK;
      skid_q <= skid_q & ~CTRL_MASK;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) main_q <= in_data;
        ONE: begin
          if (in_fire && !out_fire)     skid_q <= in_data;
          else if (in_fire && out_fire) main_q <= in_data;
          else if (out_fire)            main_q <= main_q & ~CTRL_MASK;
        end
        TWO:   if (out_fire) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  // Stall counter; only reset clears it.
  sat_counter #(
    .W(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~rdy_eff),
    .clear(1'b0),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a
// queue-based reference model. Two instances share stimulus; the second has a
// 3-bit stall counter to exercise saturation.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, freeze, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, in_ready_b, out_valid_b;
  logic [W-1:0]  out_data, out_data_b;
  logic [1:0]    occupancy, occupancy_b;
  logic [15:0]   stall_cnt;
  logic [2:0]    stall_cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of held bundles plus saturating stall counts.
  logic [W-1:0] q[$];
  int unsigned  cnt_a = 0;
  int unsigned  cnt_b = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .CTRL_WIDTH(CW), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(W), .CTRL_WIDTH(CW), .CNT_WIDTH(3)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .occupancy(occupancy_b), .stall_cnt(stall_cnt_b)
  );

  // Advance one rising edge, updating the model from the inputs presented before it.
  task automatic tick();
    bit stage_ready, downstream_take, accept, deliver;
    stage_ready     = q.size() < 2;
    downstream_take = out_ready && !freeze;
    accept          = in_valid && stage_ready;
    deliver         = (q.size() > 0) && downstream_take;
    if (q.size() > 0 && !downstream_take) begin
      if (cnt_a < 65535) cnt_a++;
      if (cnt_b < 7)     cnt_b++;
    end
    if (flush) begin
      q.delete();
    end else begin
      if (deliver) void'(q.pop_front());
      if (accept)  q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
  endtask

  // Reset between edges and release one cycle later, away from the clock edge.
  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    q.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic [W-1:0] v;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      v = W'(i);
      in_data = v;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== v) begin errors++; $display("FAIL stream_data%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, v); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ%0d: got %0d expected 1", i, occupancy); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_skid();
    logic [W-1:0] a, b;
    a = 32'hA5A5_0011; b = 32'h5A5A_0016;
    in_valid = 1'b1; in_data = a; out_ready = 1'b1;
    tick();
    in_data = b; out_ready = 1'b0;
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL skid_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occupancy, in_ready); end
    checks++; if (out_data !== a) begin errors++; $display("FAIL skid_head: got %h expected %h", out_data, a); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_data !== b || in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL skid_second: got d=%h rdy=%b occ=%0d expected d=%h rdy=1 occ=1", out_data, in_ready, occupancy, b); end
    tick();
    checks++; if (occupancy !== 2'd0 || out_data[CW-1:0] !== 5'd0) begin errors++; $display("FAIL skid_empty: got occ=%0d ctrl=%h expected occ=0 ctrl=0", occupancy, out_data[CW-1:0]); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL skid_stall_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h1111_001F;
    tick();
    in_data = 32'h2222_003F;
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill: got occ=%0d expected 2", occupancy); end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hDEAD_BE0F;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got v=%b occ=%0d rdy=%b expected v=0 occ=0 rdy=1", out_valid, occupancy, in_ready); end
    checks++; if (out_data[CW-1:0] !== 5'd0) begin errors++; $display("FAIL flush_ctrl: got %h expected 0", out_data[CW-1:0]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped%0d: got v=%b d=%h expected v=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_freeze();
    logic [W-1:0] z;
    z = 32'hCAFE_0007;
    apply_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_data = z;
    tick();
    in_valid = 1'b0; freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== z) begin errors++; $display("FAIL freeze_hold%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, z); end
    end
    checks++; if (stall_cnt_b !== 3'd7) begin errors++; $display("FAIL freeze_sat3: got %0d expected 7", stall_cnt_b); end
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL freeze_cnt16: got %0d expected 10", stall_cnt); end
    freeze = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL freeze_release: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    checks++; if (stall_cnt_b !== 3'd7) begin errors++; $display("FAIL freeze_sat3_hold: got %0d expected 7", stall_cnt_b); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h0BAD_001D;
    tick();
    in_data = 32'h0BAD_0019;
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL areset_fill: got occ=%0d expected 2", occupancy); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL areset_out: got v=%b d=%h expected v=0 d=0", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin errors++; $display("FAIL areset_state: got rdy=%b occ=%0d expected rdy=1 occ=0", in_ready, occupancy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL areset_cnt: got %0d expected 0", stall_cnt); end
    idle_inputs();
    q.delete(); cnt_a = 0; cnt_b = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] seq;
    seq = 16'd0;
    for (int n = 0; n < 10000; n++) begin
      in_valid  = $urandom_range(0, 99) < 60;
      out_ready = $urandom_range(0, 99) < 70;
      freeze    = $urandom_range(0, 99) < 10;
      flush     = $urandom_range(0, 99) < 2;
      in_data   = {seq, 16'($urandom)};
      seq       = seq + 16'd1;
      tick();
      checks++; if (occupancy !== 2'(q.size())) begin errors++; $display("FAIL rand_occ@%0d: got %0d expected %0d", n, occupancy, q.size()); end
      checks++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_hs@%0d: got v=%b rdy=%b expected size %0d", n, out_valid, in_ready, q.size()); end
      if (q.size() > 0) begin
        checks++; if (out_data !== q[0] || out_data_b !== q[0]) begin errors++; $display("FAIL rand_order@%0d: got %h/%h expected %h", n, out_data, out_data_b, q[0]); end
      end else begin
        checks++; if (out_data[CW-1:0] !== 5'd0) begin errors++; $display("FAIL rand_bubble@%0d: got ctrl %h expected 0", n, out_data[CW-1:0]); end
      end
      checks++; if (stall_cnt !== 16'(cnt_a) || stall_cnt_b !== 3'(cnt_b)) begin errors++; $display("FAIL rand_stall@%0d: got %0d/%0d expected %0d/%0d", n, stall_cnt, stall_cnt_b, cnt_a, cnt_b); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_freeze();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register that replaces the fixed per-field stage registers between ID/EX, EX/MEM and MEM/WB. It carries one packed bundle per stage with a valid/ready handshake and a 2-entry skid buffer, so upstream ready is registered and never combinationally depends on downstream. Synchronous flush turns every held entry into a bubble. A freeze input stalls the stage, and a saturating stall counter supports hazard debugging. One instance sits at each stage boundary of the ARM pipeline.

## Interface
Parameters:
- WIDTH, 150: total bundle width in bits; 150 is the ID/EX bundle.
- CTRL_WIDTH, 5: number of low-order bundle bits that are control (WB_EN, MEM_R_EN, MEM_W_EN, B, S for ID/EX). Legal range is 0..WIDTH.
- CNT_WIDTH, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush; discards all held entries and any input offered this cycle.
- freeze  in  1  stall; forces the effective downstream ready to 0.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  WIDTH  upstream bundle.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  output bundle.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_WIDTH  saturating count of stalled cycles.

## Operation
- Storage: main entry (drives out_data) and skid entry.
- Definitions: in_fire = in_valid & in_ready; rdy_eff = out_ready & ~freeze; out_fire = out_valid & rdy_eff.
- FSM states and outputs:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ONE: occupancy 1, out_valid 1, in_ready 1.
  - TWO: occupancy 2, out_valid 1, in_ready 0.
- Transitions, with flush = 0:
  - EMPTY, in_fire: main <= in_data; go to ONE.
  - ONE, in_fire & ~out_fire: skid <= in_data; go to TWO.
  - ONE, in_fire & out_fire: main <= in_data; stay in ONE.
  - ONE, ~in_fire & out_fire: go to EMPTY.
  - TWO, out_fire: main <= skid; go to ONE. No input is accepted, since in_ready = 0.
  - All other cases: hold.
- Ordering: bundles leave in arrival order, with no loss and no duplication.
- Flush has highest priority over all transitions:
  - Next state is EMPTY.
  - Control bits [CTRL_WIDTH-1:0] of main and skid are cleared to 0.
  - Data bits hold their values.
  - An in_fire in the same cycle is dropped.
  - Flush takes precedence over a simultaneous out_fire. The downstream must itself ignore the bundle it samples in the flush cycle.
- Bubble guarantee: whenever out_valid = 0, out_data[CTRL_WIDTH-1:0] = 0. Downstream may ignore out_valid and still see a NOP.
- stall_cnt:
  - Increments when out_valid & ~rdy_eff.
  - Saturates at all-ones; it never wraps.
  - Cleared only by reset; flush does not clear it.
- Reset (asynchronous, rst = 0):
  - State is EMPTY.
  - main, skid, out_data and stall_cnt are 0.
  - in_ready = 1, out_valid = 0, occupancy = 0.
  - Reset asserted mid-transfer discards all content immediately.

## Timing
- Latency: a bundle accepted at edge n appears on out_data with out_valid = 1 after edge n, i.e. 1 cycle.
- Throughput: 1 bundle per cycle when out_ready = 1 and freeze = 0.
- in_ready:
  - Driven from the state register only; no combinational path from out_ready or freeze.
  - After downstream stalls for 1 cycle with a new input accepted, in_ready drops at the following edge.
  - The skid entry absorbs the one in-flight bundle.
- Freeze: effective at the same edge; it is identical to out_ready = 0 for one cycle.
- Flush: effective at the next edge; out_valid = 0 and in_ready = 1 in the following cycle.
- Combinational outputs: out_valid, in_ready and occupancy are decoded from state only.

## Structure
- Package pipe_pkg holds:
  - The state enum {EMPTY, ONE, TWO}.
  - Bundle width constants ID_EX_W = 150, EX_MEM_W and MEM_WB_W.
  - Field offset localparams for the ID/EX bundle. Control is bits [4:0]; then SR[8:5], EXE_CMD[12:9], PC, Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest.
- One sub-module, sat_counter (parameter W; inputs inc and clear; output cnt), used for stall_cnt.
- Stage wrappers pack and unpack the bundle using the pipe_pkg offsets. They contain no logic.

## Test plan
- **Reset and streaming.** Release reset, drive in_valid = 1 with data 1, 2, 3 and out_ready = 1. Required: out_data shows 1, 2, 3 on consecutive cycles, one cycle after each is accepted; occupancy = 1 throughout; stall_cnt = 0.
- **Skid fill and drain.** Accept A, then drop out_ready while B is offered. Required: occupancy = 2 and in_ready = 0 next cycle. Raise out_ready: out_data shows A then B, and in_ready returns to 1.
- **Flush while full.** Fill the stage with two bundles whose control bits are 5'b11111, then pulse flush with in_valid = 1. Required: next cycle out_valid = 0, out_data[4:0] = 0, occupancy = 0, and the offered input never appears at the output.
- **Freeze and saturation.** With CNT_WIDTH = 3, hold freeze = 1 for 10 cycles while the stage holds one bundle. Required: out_data is held, stall_cnt = 7 (saturated), and the bundle is delivered on the first cycle after freeze = 0.
- **Asynchronous reset mid-operation.** Assert rst = 0 between clock edges while occupancy = 2. Required: out_valid = 0 and out_data = 0 immediately without a clock edge; in_ready = 1.
- **Randomized ordering check.** Drive random in_valid, out_ready and freeze for 10k cycles against a scoreboard. Required: in-order delivery with no loss or duplication, and out_data[4:0] = 0 whenever out_valid = 0.
